// File: rtl/control_transfer_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : control_transfer_unit
// Description : Executes JAL, JALR and conditional branches. Target addition
//               is done on a shared ALU; traps and link writes go out on done.
// Revision    : 1.0 - initial release
// ============================================================================
module control_transfer_unit #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned REG_SELECT_LEN = 5,
    parameter bit          COMPRESSED     = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [31:0]               instruction,
    input  logic [XLEN-1:0]           program_counter,
    input  logic [XLEN-1:0]           rs1_data,
    input  logic [XLEN-1:0]           rs2_data,
    output logic                      alu_req,
    output logic [XLEN-1:0]           alu_a,
    output logic [XLEN-1:0]           alu_b,
    output logic [2:0]                alu_op,
    output logic                      alu_signal,
    input  logic                      alu_ack,
    input  logic [XLEN-1:0]           alu_out,
    output logic                      busy,
    output logic                      done,
    output logic                      load_new_program_counter,
    output logic [XLEN-1:0]           new_program_counter,
    output logic                      reg_write,
    output logic [REG_SELECT_LEN-1:0] output_register,
    output logic [XLEN-1:0]           output_register_data,
    output logic                      misaligned,
    output logic                      illegal
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ALU_WAIT = 2'd1,
        COMMIT   = 2'd2
    } state_t;

    localparam logic [6:0] C_OP_JAL    = 7'b1101111;
    localparam logic [6:0] C_OP_JALR   = 7'b1100111;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;

    state_t                    r_state;
    logic                      r_is_jalr;
    logic                      r_is_jump;
    logic [REG_SELECT_LEN-1:0] r_rd;
    logic [XLEN-1:0]           r_link;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic            w_is_jal;
    logic            w_is_jalr;
    logic            w_is_branch;
    logic            w_illegal;
    logic            w_taken;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_target;
    logic            w_target_misaligned;

    assign w_opcode    = instruction[6:0];
    assign w_funct3    = instruction[14:12];
    assign w_is_jal    = (w_opcode == C_OP_JAL);
    assign w_is_jalr   = (w_opcode == C_OP_JALR) && (w_funct3 == 3'b000);
    assign w_is_branch = (w_opcode == C_OP_BRANCH) &&
                         (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
    assign w_illegal   = !(w_is_jal || w_is_jalr || w_is_branch);

    assign w_imm_i = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
    assign w_imm_j = {{(XLEN-21){instruction[31]}}, instruction[31], instruction[19:12],
                      instruction[20], instruction[30:21], 1'b0};
    assign w_imm_b = {{(XLEN-13){instruction[31]}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};
    assign w_imm   = w_is_jal ? w_imm_j : (w_is_jalr ? w_imm_i : w_imm_b);

    // Branch decision is made on the operands at the sampling edge, so a
    // not-taken branch can skip the ALU entirely.
    always_comb begin
        w_taken = 1'b0;
        case (w_funct3)
            3'b000:  w_taken = (rs1_data == rs2_data);
            3'b001:  w_taken = (rs1_data != rs2_data);
            3'b100:  w_taken = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  w_taken = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  w_taken = (rs1_data <  rs2_data);
            3'b111:  w_taken = (rs1_data >= rs2_data);
            default: w_taken = 1'b0;
        endcase
    end

    assign w_target            = {alu_out[XLEN-1:1], alu_out[0] & ~r_is_jalr};
    assign w_target_misaligned = w_target[1] && (COMPRESSED == 1'b0);

    assign busy       = (r_state != IDLE);
    assign alu_op     = 3'b000;
    assign alu_signal = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state                  <= IDLE;
            r_is_jalr                <= 1'b0;
            r_is_jump                <= 1'b0;
            r_rd                     <= '0;
            r_link                   <= '0;
            alu_req                  <= 1'b0;
            alu_a                    <= '0;
            alu_b                    <= '0;
            done                     <= 1'b0;
            load_new_program_counter <= 1'b0;
            new_program_counter      <= '0;
            reg_write                <= 1'b0;
            output_register          <= '0;
            output_register_data     <= '0;
            misaligned               <= 1'b0;
            illegal                  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_is_jalr <= w_is_jalr;
                        r_is_jump <= w_is_jal || w_is_jalr;
                        r_rd      <= REG_SELECT_LEN'(instruction[11:7]);
                        r_link    <= program_counter + XLEN'(4);
                        if (w_is_jal || w_is_jalr || (w_is_branch && w_taken)) begin
                            r_state <= ALU_WAIT;
                            alu_req <= 1'b1;
                            alu_a   <= w_is_jalr ? rs1_data : program_counter;
                            alu_b   <= w_imm;
                        end else begin
                            r_state <= COMMIT;
                            done    <= 1'b1;
                            illegal <= w_illegal;
                        end
                    end
                end
                ALU_WAIT: begin
                    if (alu_ack) begin
                        r_state <= COMMIT;
                        alu_req <= 1'b0;
                        alu_a   <= '0;
                        alu_b   <= '0;
                        done    <= 1'b1;
                        if (w_target_misaligned) begin
                            misaligned <= 1'b1;
                        end else begin
                            load_new_program_counter <= 1'b1;
                            new_program_counter      <= w_target;
                            if (r_is_jump) begin
                                output_register      <= r_rd;
                                output_register_data <= r_link;
                                reg_write            <= (r_rd != '0);
                            end
                        end
                    end
                end
                COMMIT: begin
                    r_state                  <= IDLE;
                    done                     <= 1'b0;
                    load_new_program_counter <= 1'b0;
                    new_program_counter      <= '0;
                    reg_write                <= 1'b0;
                    output_register          <= '0;
                    output_register_data     <= '0;
                    misaligned               <= 1'b0;
                    illegal                  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_transfer_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_control_transfer_unit
// Description : Directed and random transactions on two instances (4-byte and
//               2-byte alignment) checked against an instruction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_transfer_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        alu_ack = 1'b0;
    logic [31:0] instruction = '0;
    logic [31:0] program_counter = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [31:0] alu_out = '0;

    logic        alu_req [2];
    logic [31:0] alu_a   [2];
    logic [31:0] alu_b   [2];
    logic [2:0]  alu_op  [2];
    logic        alu_signal [2];
    logic        busy    [2];
    logic        done    [2];
    logic        load_npc [2];
    logic [31:0] npc     [2];
    logic        reg_write [2];
    logic [4:0]  out_reg [2];
    logic [31:0] out_data [2];
    logic        misaligned [2];
    logic        illegal [2];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    control_transfer_unit #(.XLEN(32), .REG_SELECT_LEN(5), .COMPRESSED(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .instruction(instruction),
        .program_counter(program_counter), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .alu_req(alu_req[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op(alu_op[0]),
        .alu_signal(alu_signal[0]), .alu_ack(alu_ack), .alu_out(alu_out),
        .busy(busy[0]), .done(done[0]), .load_new_program_counter(load_npc[0]),
        .new_program_counter(npc[0]), .reg_write(reg_write[0]),
        .output_register(out_reg[0]), .output_register_data(out_data[0]),
        .misaligned(misaligned[0]), .illegal(illegal[0]));

    control_transfer_unit #(.XLEN(32), .REG_SELECT_LEN(5), .COMPRESSED(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .instruction(instruction),
        .program_counter(program_counter), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .alu_req(alu_req[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op(alu_op[1]),
        .alu_signal(alu_signal[1]), .alu_ack(alu_ack), .alu_out(alu_out),
        .busy(busy[1]), .done(done[1]), .load_new_program_counter(load_npc[1]),
        .new_program_counter(npc[1]), .reg_write(reg_write[1]),
        .output_register(out_reg[1]), .output_register_data(out_data[1]),
        .misaligned(misaligned[1]), .illegal(illegal[1]));

    typedef struct {
        bit          needs_alu;
        bit          is_illegal;
        bit          is_jump;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] target;
        logic [4:0]  rd;
        logic [31:0] link;
    } exp_t;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1f,
                                             input logic [2:0] f3, input logic [11:0] imm);
        return {imm, rs1f, f3, rd, 7'b1100111};
    endfunction

    function automatic logic [31:0] enc_br(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    // Instruction-level reference: what the unit should do with one request.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] imm;
        bit          jal, jalr, br, taken;
        op   = ins[6:0];
        f3   = ins[14:12];
        jal  = (op == 7'b1101111);
        jalr = (op == 7'b1100111) && (f3 == 3'd0);
        br   = (op == 7'b1100011) && (f3 != 3'd2) && (f3 != 3'd3);
        case (f3)
            3'd0:    taken = (r1 == r2);
            3'd1:    taken = (r1 != r2);
            3'd4:    taken = ($signed(r1) <  $signed(r2));
            3'd5:    taken = ($signed(r1) >= $signed(r2));
            3'd6:    taken = (r1 <  r2);
            default: taken = (r1 >= r2);
        endcase
        if (jal)       imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        else if (jalr) imm = {{20{ins[31]}}, ins[31:20]};
        else           imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        e.needs_alu  = jal || jalr || (br && taken);
        e.is_illegal = !(jal || jalr || br);
        e.is_jump    = jal || jalr;
        e.a          = jalr ? r1 : pc;
        e.b          = imm;
        e.target     = jalr ? ((r1 + imm) & ~32'd1) : (pc + imm);
        e.rd         = ins[11:7];
        e.link       = pc + 32'd4;
        return e;
    endfunction

    task automatic check_quiet(input int k, input string tag);
        check_val($sformatf("%s%0d_busy", tag, k), busy[k], 0);
        check_val($sformatf("%s%0d_done", tag, k), done[k], 0);
        check_val($sformatf("%s%0d_alu_req", tag, k), alu_req[k], 0);
        check_val($sformatf("%s%0d_alu_a", tag, k), alu_a[k], 0);
        check_val($sformatf("%s%0d_alu_b", tag, k), alu_b[k], 0);
        check_val($sformatf("%s%0d_alu_sig", tag, k), {alu_op[k], alu_signal[k]}, 0);
        check_val($sformatf("%s%0d_load", tag, k), load_npc[k], 0);
        check_val($sformatf("%s%0d_npc", tag, k), npc[k], 0);
        check_val($sformatf("%s%0d_wr", tag, k), reg_write[k], 0);
        check_val($sformatf("%s%0d_rd", tag, k), out_reg[k], 0);
        check_val($sformatf("%s%0d_data", tag, k), out_data[k], 0);
        check_val($sformatf("%s%0d_flags", tag, k), {misaligned[k], illegal[k]}, 0);
    endtask

    task automatic check_commit(input int k, input exp_t e, input string tag);
        bit mis;
        mis = e.needs_alu && e.target[1] && (k == 0);
        check_val($sformatf("%s%0d_done", tag, k), done[k], 1);
        check_val($sformatf("%s%0d_busy", tag, k), busy[k], 1);
        check_val($sformatf("%s%0d_alu_req", tag, k), alu_req[k], 0);
        check_val($sformatf("%s%0d_illegal", tag, k), illegal[k], e.is_illegal);
        check_val($sformatf("%s%0d_misal", tag, k), misaligned[k], mis);
        check_val($sformatf("%s%0d_load", tag, k), load_npc[k], e.needs_alu && !mis);
        check_val($sformatf("%s%0d_wr", tag, k), reg_write[k],
                  e.is_jump && !mis && (e.rd != 5'd0));
        if (e.needs_alu && !mis)
            check_val($sformatf("%s%0d_npc", tag, k), npc[k], e.target);
        if (e.is_jump && !mis) begin
            check_val($sformatf("%s%0d_rd", tag, k), out_reg[k], e.rd);
            check_val($sformatf("%s%0d_data", tag, k), out_data[k], e.link);
        end
    endtask

    // Entry and exit point: 1 time unit after a rising edge, both units idle.
    // With noise set, start stays high with junk while the units are busy.
    task automatic run_txn(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                           input logic [31:0] r1, input logic [31:0] r2,
                           input int stall, input bit noise);
        exp_t e;
        e = model(ins, pc, r1, r2);
        start = 1'b1; instruction = ins; program_counter = pc; rs1_data = r1; rs2_data = r2;
        @(posedge clk); #1;
        if (noise) begin
            instruction = $urandom; program_counter = $urandom;
            rs1_data = $urandom; rs2_data = $urandom;
        end else begin
            start = 1'b0;
        end
        if (e.needs_alu) begin
            for (int s = 0; s <= stall; s++) begin
                for (int k = 0; k < 2; k++) begin
                    check_val($sformatf("%s%0d_req", tag, k), alu_req[k], 1);
                    check_val($sformatf("%s%0d_wait_done", tag, k), done[k], 0);
                    check_val($sformatf("%s%0d_a", tag, k), alu_a[k], e.a);
                    check_val($sformatf("%s%0d_b", tag, k), alu_b[k], e.b);
                    check_val($sformatf("%s%0d_op", tag, k), alu_op[k], 0);
                end
                alu_ack = (s == stall);
                alu_out = (s == stall) ? e.a + e.b : $urandom;
                @(posedge clk); #1;
            end
            alu_ack = 1'b0;
            alu_out = $urandom;
        end
        for (int k = 0; k < 2; k++) check_commit(k, e, tag);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 2; k++) check_quiet(k, {tag, "_after"});
    endtask

    task automatic reset_mid_op();
        start = 1'b1; instruction = enc_jal(5'd1, 21'd8); program_counter = 32'h100;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 2; k++) check_val($sformatf("rst_pre%0d_req", k), alu_req[k], 1);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) check_quiet(k, "rst_async");
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        alu_ack = 1'b1; alu_out = 32'h108;
        @(posedge clk); #1;
        alu_ack = 1'b0;
        for (int k = 0; k < 2; k++) check_quiet(k, "rst_post");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins, pc, r1, r2;
        int          sel;
        #1;
        for (int k = 0; k < 2; k++) check_quiet(k, "reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_txn("jal_x1", enc_jal(5'd1, 21'd8), 32'h100, 32'h0, 32'h0, 0, 1'b0);
        run_txn("jalr_x5", enc_jalr(5'd5, 5'd2, 3'd0, 12'd3), 32'h300, 32'h201, 32'h0, 0, 1'b0);
        run_txn("bltu", enc_br(3'd6, 13'd16), 32'h400, 32'h1, 32'hFFFF_FFFF, 0, 1'b0);
        run_txn("blt", enc_br(3'd4, 13'd16), 32'h400, 32'h1, 32'hFFFF_FFFF, 0, 1'b0);
        run_txn("jal_p6", enc_jal(5'd1, 21'd6), 32'h100, 32'h0, 32'h0, 0, 1'b0);
        run_txn("jal_x0_wrap", enc_jal(5'd0, 21'd8), 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 1'b0);
        run_txn("jal_x1_wrap", enc_jal(5'd1, 21'd8), 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 1'b0);
        run_txn("op_0110011", 32'h00B5_0533, 32'h200, 32'h5, 32'h6, 0, 1'b0);
        run_txn("jalr_f3", enc_jalr(5'd3, 5'd1, 3'd1, 12'd4), 32'h200, 32'h10, 32'h0, 0, 1'b0);
        run_txn("br_f3_2", enc_br(3'd2, 13'd8), 32'h200, 32'h7, 32'h7, 0, 1'b0);
        run_txn("beq_stall", enc_br(3'd0, 13'h1FF8), 32'h1000, 32'h9, 32'h9, 3, 1'b1);
        run_txn("bge_nt_noise", enc_br(3'd5, 13'd12), 32'h80, 32'hFFFF_FFFF, 32'h1, 0, 1'b1);
        reset_mid_op();
        run_txn("after_rst", enc_jal(5'd7, 21'h1FFFF0), 32'h2000, 32'h0, 32'h0, 1, 1'b0);

        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 5);
            pc  = $urandom & 32'hFFFF_FFFC;
            r1  = $urandom;
            r2  = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
            case (sel)
                0:       ins = enc_jal(5'($urandom), 21'($urandom));
                1:       ins = enc_jalr(5'($urandom), 5'($urandom), 3'd0, 12'($urandom));
                2, 3:    ins = enc_br(3'($urandom), 13'($urandom));
                4:       ins = enc_jalr(5'($urandom), 5'($urandom), 3'($urandom), 12'($urandom));
                default: ins = $urandom;
            endcase
            run_txn($sformatf("rnd%0d", i), ins, pc, r1, r2,
                    int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_transfer_unit.md
CONTROL_TRANSFER_UNIT -- requirements
Module: control_transfer_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath and program-counter width.
REQ-002 Parameter REG_SELECT_LEN, default 5, destination-register select width.
REQ-003 Parameter COMPRESSED, default 0; 1 allows 2-byte-aligned targets, 0 requires 4-byte alignment.
REQ-004 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 start  in  1  one-cycle request; sampled only in IDLE.
REQ-008 instruction  in  32  instruction word, sampled with start.
REQ-009 program_counter  in  XLEN  PC of the instruction, sampled with start.
REQ-010 rs1_data, rs2_data  in  XLEN each  source operands, sampled with start.
REQ-011 alu_req  out  1  request to the shared ALU; held until alu_ack.
REQ-012 alu_a, alu_b  out  XLEN each  ALU operands, stable while alu_req is high.
REQ-013 alu_op  out  3  ALU operation; always 3'b000 (add) when alu_req is high.
REQ-014 alu_signal  out  1  ALU modifier; always 0.
REQ-015 alu_ack  in  1  ALU result valid this cycle.
REQ-016 alu_out  in  XLEN  ALU result.
REQ-017 busy  out  1  high in every state other than IDLE.
REQ-018 done  out  1  one-cycle completion pulse; the commit outputs below are valid only while done is high.
REQ-019 load_new_program_counter  out  1  redirect the PC to new_program_counter.
REQ-020 new_program_counter  out  XLEN  redirect target.
REQ-021 reg_write  out  1  write output_register_data to output_register.
REQ-022 output_register  out  REG_SELECT_LEN  destination register (rd).
REQ-023 output_register_data  out  XLEN  link value.
REQ-024 misaligned  out  1  target-misaligned trap, pulsed with done.
REQ-025 illegal  out  1  unsupported encoding, pulsed with done.

Function
REQ-026 The FSM SHALL have three states: IDLE, ALU_WAIT and COMMIT.
REQ-027 In IDLE, start SHALL latch all inputs and classify the instruction.
- JAL: opcode 1101111.
- JALR: opcode 1100111 with funct3 000.
- Branch: opcode 1100011 with funct3 in {000, 001, 100, 101, 110, 111}.
- Anything else is illegal.
REQ-028 Immediates SHALL be sign-extended to XLEN.
- JAL: J-immediate.
- JALR: I-immediate.
- Branch: B-immediate.
- Bit 0 of the J- and B-immediates is 0.
REQ-029 Branch conditions SHALL be computed internally on the latched operands: BEQ, BNE, BLT/BGE signed, BLTU/BGEU unsigned.
REQ-030 From IDLE, the next state SHALL be:
- ALU_WAIT for JAL, JALR and taken branches;
- COMMIT directly for not-taken branches and illegal encodings.
REQ-031 In ALU_WAIT, operands SHALL be:
- JAL and branch: alu_a = latched PC, alu_b = immediate;
- JALR: alu_a = rs1_data, alu_b = immediate.
REQ-032 alu_req SHALL stay high until a cycle with alu_ack high; alu_out SHALL be captured in that cycle and the FSM SHALL move to COMMIT.
REQ-033 For JALR, the captured target SHALL have bit 0 cleared.
REQ-034 COMMIT SHALL last exactly one cycle: done=1, then return to IDLE.
REQ-035 The target SHALL be misaligned when bit 1 is set and COMPRESSED=0 (bit 0 is always 0).
- Misaligned: misaligned=1, load_new_program_counter=0, reg_write=0.
REQ-036 On a valid jump or taken branch: load_new_program_counter=1 and new_program_counter = target.
REQ-037 On a not-taken branch: done=1 with load_new_program_counter=0 and reg_write=0.
REQ-038 On an illegal encoding: illegal=1, with no redirect and no write.
REQ-039 For JAL/JALR without a trap:
- output_register = instruction[11:7];
- output_register_data = PC + 4, modulo 2^XLEN;
- reg_write = 1 unless rd = 0.
REQ-040 Outside COMMIT, all commit outputs SHALL be 0.
REQ-041 Outside ALU_WAIT, alu_req, alu_a and alu_b SHALL be 0.
- No output is ever high-impedance.
REQ-042 start SHALL be ignored while busy=1; there is no queueing.
REQ-043 Latency: start at cycle N with alu_ack at N+1 SHALL give done at N+2; each extra ALU stall cycle adds one cycle.
REQ-044 A not-taken branch or illegal encoding started at cycle N SHALL give done at N+1.

Reset
REQ-045 While rst=1, the FSM SHALL be in IDLE and every output SHALL be 0, asynchronously.
- Applies mid-operation as well: alu_req drops immediately and no done is issued for the aborted instruction.
REQ-046 After rst falls, the first start SHALL be accepted normally.

Verification
REQ-047 JAL x1,+8 at PC 0x100, ack at the next cycle -> done two cycles after start; new_program_counter=0x108, reg_write=1, rd=1, data=0x104.
REQ-048 JALR x5,3(x2), rs1=0x201 -> alu_a=0x201, alu_b=3; target 0x204, data=PC+4.
REQ-049 BLTU with rs1=1, rs2=0xFFFFFFFF -> taken; BLT with the same operands -> not taken, done one cycle after start, no redirect.
REQ-050 JAL +6 with COMPRESSED=0 -> misaligned=1, no redirect, no write; with COMPRESSED=1 -> redirect to PC+6.
REQ-051 JAL x0 at PC 0xFFFFFFFC -> reg_write=0.
- Same instruction to rd=1 -> data=0x00000000 (wrap-around).
REQ-052 Reset mid-operation and boundary stimuli:
- rst asserted during ALU_WAIT with ack withheld -> alu_req=0 the same cycle, no done;
- start pulsed while busy -> ignored;
- opcode 0110011 -> illegal=1.
